// File: rtl/alu_core.sv
// Registered integer ALU for the execute stage: one operation per cycle, result
// and status flags captured on the rising edge with a fixed one-cycle latency.
module alu_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALUControl,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Overflow,
   output logic             CarryOut
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SRA  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;
   localparam logic [3:0] OP_NOR  = 4'b1100;

   // There is no handshake: every cycle's inputs are an accepted operation,
   // and its outputs are valid from the following edge until the next one.

   logic [WIDTH:0]   add_full;
   logic [WIDTH:0]   sub_full;
   logic             add_ovf;
   logic             sub_ovf;
   logic             slt_bit;
   logic             sltu_bit;
   logic [SHW-1:0]   sh;

   logic [WIDTH-1:0] result_d, result_q;
   logic             zero_d, zero_q;
   logic             ovf_d, ovf_q;
   logic             carry_d, carry_q;

   // Subtraction as A + ~B + 1 so the top bit is the no-borrow flag directly.
   assign add_full = {1'b0, A} + {1'b0, B};
   assign sub_full = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

   assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
   assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_full[WIDTH-1] != A[WIDTH-1]);

   // Sign of the difference corrected by overflow keeps SLT right at the extremes.
   assign slt_bit  = sub_full[WIDTH-1] ^ sub_ovf;
   assign sltu_bit = ~sub_full[WIDTH];

   assign sh = B[SHW-1:0];

   always_comb begin
      result_d = '0;
      ovf_d    = 1'b0;
      carry_d  = 1'b0;
      case (ALUControl)
         OP_AND:  result_d = A & B;
         OP_OR:   result_d = A | B;
         OP_ADD: begin
            result_d = add_full[WIDTH-1:0];
            ovf_d    = add_ovf;
            carry_d  = add_full[WIDTH];
         end
         OP_XOR:  result_d = A ^ B;
         OP_SLL:  result_d = A << sh;
         OP_SRL:  result_d = A >> sh;
         OP_SUB: begin
            result_d = sub_full[WIDTH-1:0];
            ovf_d    = sub_ovf;
            carry_d  = sub_full[WIDTH];
         end
         OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, slt_bit};
         OP_SRA:  result_d = $unsigned($signed(A) >>> sh);
         OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, sltu_bit};
         OP_NOR:  result_d = ~(A | B);
         default: result_d = '0;
      endcase
      zero_d = (result_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_q <= '0;
         zero_q   <= 1'b1;
         ovf_q    <= 1'b0;
         carry_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         carry_q  <= carry_d;
      end
   end

   assign Result   = result_q;
   assign Zero     = zero_q;
   assign Overflow = ovf_q;
   assign CarryOut = carry_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: hand-computed vectors checked one edge after
// they are driven, including reset, flag corners, shifts and undefined opcodes.
module tb_alu_core;
   localparam int W = 32;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SRA  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;
   localparam logic [3:0] OP_NOR  = 4'b1100;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] A, B;
   logic [3:0]   ALUControl;
   logic [W-1:0] Result;
   logic         Zero, Overflow, CarryOut;

   int vectors     = 0;
   int miscompares = 0;

   // {Result, Zero, Overflow, CarryOut}
   logic [W+2:0] exp_q[$];

   alu_core #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .A          (A),
      .B          (B),
      .ALUControl (ALUControl),
      .Result     (Result),
      .Zero       (Zero),
      .Overflow   (Overflow),
      .CarryOut   (CarryOut)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W+2:0] exp);
      logic [W+2:0] act;
      act = {Result, Zero, Overflow, CarryOut};
      vectors++;
      assert (act === exp) else begin
         miscompares++;
         $error("FAIL %s: got R=%h Z=%b V=%b C=%b, want R=%h Z=%b V=%b C=%b",
                tag, act[W+2:3], act[2], act[1], act[0],
                exp[W+2:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      ALUControl = op;
      A          = a;
      B          = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input string tag, input logic [3:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] r, input logic z, input logic v, input logic c);
      drive(op, a, b);
      tick();
      check(tag, {r, z, v, c});
   endtask

   initial begin
      logic [3:0] undef_ops [5];
      undef_ops = '{4'b1010, 4'b1011, 4'b1101, 4'b1110, 4'b1111};

      // Reset held for two edges with busy inputs.
      rst_n = 1'b0;
      drive(OP_ADD, 32'h1234_5678, 32'h0000_0001);
      tick();
      check("reset_edge1", {32'h0, 1'b1, 1'b0, 1'b0});
      drive(OP_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      tick();
      check("reset_edge2", {32'h0, 1'b1, 1'b0, 1'b0});
      rst_n = 1'b1;

      run("add_basic",   OP_ADD, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 0, 0, 0);
      run("add_wrap",    OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1);
      run("add_ovf",     OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1, 0);
      run("add_negovf",  OP_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, 1, 1);

      run("sub_basic",   OP_SUB, 32'h0000_0030, 32'h0000_0010, 32'h0000_0020, 0, 0, 1);
      run("sub_equal",   OP_SUB, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1, 0, 1);
      run("sub_ovf",     OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 1, 1);
      run("sub_borrow",  OP_SUB, 32'h0000_0010, 32'h0000_0030, 32'hFFFF_FFE0, 0, 0, 0);

      run("and",         OP_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 1, 0, 0);
      run("or",          OP_OR,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 0, 0, 0);
      run("xor",         OP_XOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 0, 0, 0);
      run("nor",         OP_NOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 1, 0, 0);
      run("nor_zero",    OP_NOR, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0, 0);

      run("slt_neg",     OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0, 0, 0);
      run("sltu_neg",    OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 0);
      run("slt_ovf",     OP_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 0, 0, 0);
      run("slt_ovf_rev", OP_SLT,  32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1, 0, 0);
      run("sltu_less",   OP_SLTU, 32'h0000_0001, 32'h8000_0000, 32'h0000_0001, 0, 0, 0);

      run("sll_31",      OP_SLL, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 0, 0, 0);
      run("sra_4",       OP_SRA, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 0, 0, 0);
      run("srl_4",       OP_SRL, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 0, 0, 0);
      run("srl_hi_b",    OP_SRL, 32'h8000_0000, 32'hFFFF_FFE4, 32'h0800_0000, 0, 0, 0);
      run("sll_hi_b",    OP_SLL, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 0, 0, 0);
      run("sra_pos",     OP_SRA, 32'h4000_0000, 32'h0000_0002, 32'h1000_0000, 0, 0, 0);

      foreach (undef_ops[i]) begin
         run($sformatf("undef_%b", undef_ops[i]), undef_ops[i],
             32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1, 0, 0);
      end

      // Back-to-back: opcode changes every cycle, each result one edge later.
      drive(OP_AND, 32'h0000_FF00, 32'h0000_0FF0); exp_q.push_back({32'h0000_0F00, 3'b000});
      tick(); check("b2b_and", exp_q.pop_front());
      drive(OP_OR,  32'h0000_FF00, 32'h0000_0FF0); exp_q.push_back({32'h0000_FFF0, 3'b000});
      tick(); check("b2b_or", exp_q.pop_front());
      drive(OP_XOR, 32'h0000_FF00, 32'h0000_0FF0); exp_q.push_back({32'h0000_F0F0, 3'b000});
      tick(); check("b2b_xor", exp_q.pop_front());
      drive(OP_ADD, 32'h0000_0005, 32'h0000_0007); exp_q.push_back({32'h0000_000C, 3'b000});
      tick(); check("b2b_add", exp_q.pop_front());
      drive(OP_SLTU, 32'h0000_0001, 32'h0000_0002); exp_q.push_back({32'h0000_0001, 3'b000});
      tick(); check("b2b_sltu", exp_q.pop_front());
      drive(OP_SUB, 32'h0000_0002, 32'h0000_0002); exp_q.push_back({32'h0000_0000, 3'b101});
      tick(); check("b2b_sub", exp_q.pop_front());

      // Reset mid-stream overrides the operation presented at that edge.
      run("pre_reset", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 0, 0, 1);
      rst_n = 1'b0;
      drive(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
      tick();
      check("mid_reset", {32'h0, 1'b1, 1'b0, 1'b0});
      rst_n = 1'b1;
      run("post_reset", OP_OR, 32'h0000_00A0, 32'h0000_000B, 32'h0000_00AB, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Registered 32-bit integer ALU for the single-cycle/pipelined datapath execute stage.
- Combinationally computes one of several arithmetic, logic, shift or compare operations on A and B, selected by a 4-bit MIPS-style control code.
- Captures the result and status flags into output registers on the rising clock edge.
- Flag outputs feed branch logic (Zero) and exception/overflow handling (Overflow, CarryOut).

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a power of two, at least 8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- ALUControl  input  4  operation select
- Result  output  WIDTH  registered operation result
- Zero  output  1  registered; 1 when the registered Result is all zeros
- Overflow  output  1  registered signed overflow, ADD/SUB only
- CarryOut  output  1  registered carry-out (ADD) / no-borrow (SUB)

Behaviour:
- One clock domain. All outputs are flops updated only on the rising edge of clk.
- Reset: rst_n is sampled at the edge. When low: Result=0, Zero=1, Overflow=0, CarryOut=0. Reset has priority over any operation in flight.
- Latency: exactly 1 cycle. Inputs present before edge N appear on outputs after edge N. There is no handshake or enable; a new operation is accepted every cycle.
- Opcode map (SH = B[log2(WIDTH)-1:0]; B's upper bits are ignored for shifts):
  - 0000 AND: A & B
  - 0001 OR: A | B
  - 0010 ADD: A + B, modulo 2^WIDTH
  - 0011 XOR: A ^ B
  - 0100 SLL: A << SH
  - 0101 SRL: A >> SH, logical (zero fill)
  - 0110 SUB: A - B, modulo 2^WIDTH
  - 0111 SLT: 1 if signed(A) < signed(B), else 0
  - 1000 SRA: A >>> SH, arithmetic (sign fill)
  - 1001 SLTU: 1 if unsigned A < unsigned B, else 0
  - 1100 NOR: ~(A | B)
  - All other codes (1010, 1011, 1101, 1110, 1111): Result=0.
- SLT/SLTU results are zero-extended to WIDTH.
- Zero is computed from the next Result value and registered alongside it, so it always matches the registered Result, including for undefined opcodes (Zero=1).
- Overflow:
  - ADD: operands share a sign and the sum's sign differs.
  - SUB: operand signs differ and the difference's sign differs from A.
  - All other ops: 0.
- CarryOut:
  - ADD: bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: 1 when A >= B unsigned (no borrow).
  - All other ops: 0.
- SLT must be correct even when A-B overflows: use the sign of A-B XOR the overflow bit.
- X/Z on inputs carries no defined requirement. No internal state beyond the output registers.

Test Plan:
- Reset with rst_n=0 for 2 edges, any inputs -> Result=0, Zero=1, Overflow=0, CarryOut=0. Release rst_n; first operation appears after the next edge.
- ADD A=0x00000010, B=0x00000020 -> one edge later Result=0x00000030, Zero=0. Then ADD 0xFFFFFFFF+0x00000001 -> Result=0, Zero=1, CarryOut=1, Overflow=0. Then ADD 0x7FFFFFFF+1 -> 0x80000000, Overflow=1.
- SUB 0x30-0x10 -> Result=0x00000020, CarryOut=1. SUB 0x12345678-0x12345678 -> Result=0, Zero=1. SUB 0x80000000-1 -> 0x7FFFFFFF, Overflow=1.
- Logic on A=0xF0F0F0F0, B=0x0F0F0F0F:
  - AND -> 0x00000000, Zero=1
  - OR -> 0xFFFFFFFF, Zero=0
  - XOR -> 0xFFFFFFFF
  - NOR -> 0x00000000
- Compare and shift:
  - SLT A=0xFFFFFFFF, B=1 -> 1; SLTU with same operands -> 0
  - SLL A=1, B=31 -> 0x80000000
  - SRA A=0x80000000, B=4 -> 0xF8000000
  - SRL same operands -> 0x08000000
- Undefined op ALUControl=1111, A=B=1 -> Result=0, Zero=1, flags 0. Back-to-back opcode change every cycle -> each result appears exactly one cycle later. Assert rst_n low mid-stream -> outputs return to reset values at that edge.
